// File: rtl/button_pkg.sv
// Shared types and default timing constants for the button conditioning block.
package button_pkg;

  typedef enum logic [1:0] {
    StReleased    = 2'd0,
    StPressPend   = 2'd1,
    StPressed     = 2'd2,
    StReleasePend = 2'd3
  } btn_state_e;

  // Short values keep simulation fast; board values assume a 100 MHz clock.
  localparam int unsigned SimDebounceCycles    = 4;
  localparam int unsigned SimLongPressCycles   = 20;
  localparam int unsigned BoardDebounceCycles  = 1_000_000;
  localparam int unsigned BoardLongPressCycles = 100_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with a configurable reset value.
module sync_2ff #(
  parameter logic ResetValue = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic stage1_q, stage2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1_q <= ResetValue;
      stage2_q <= ResetValue;
    end else begin
      stage1_q <= d;
      stage2_q <= stage1_q;
    end
  end

  assign q = stage2_q;

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner: synchronise, debounce, and report press/release/long-press events.
module button_debounce
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = 1000,
  parameter int unsigned LONG_PRESS_CYCLES = 5000,
  parameter int unsigned COUNT_WIDTH       = 16,
  parameter bit          ACTIVE_LOW        = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   btn_raw,
  output logic                   btn_level,
  output logic                   press_pulse,
  output logic                   release_pulse,
  output logic                   long_pulse,
  output logic [COUNT_WIDTH-1:0] press_count
);

  localparam int unsigned CntW = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [CntW-1:0] DebLast  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] LongPre  = CntW'(LONG_PRESS_CYCLES - 2);
  localparam logic [CntW-1:0] LongMax  = CntW'(LONG_PRESS_CYCLES);

  logic pin_sync, btn_sync;

  sync_2ff #(
    .ResetValue(ACTIVE_LOW)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (btn_raw),
    .q    (pin_sync)
  );

  assign btn_sync = pin_sync ^ ACTIVE_LOW;

  btn_state_e             state_q, state_d;
  logic [CntW-1:0]        stable_cnt_q, stable_cnt_d;
  logic [CntW-1:0]        hold_cnt_q, hold_cnt_d;
  logic [COUNT_WIDTH-1:0] press_count_q, press_count_d;
  logic                   btn_level_q, btn_level_d;
  logic                   press_pulse_q, press_pulse_d;
  logic                   release_pulse_q, release_pulse_d;
  logic                   long_pulse_q, long_pulse_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StReleased;
      stable_cnt_q    <= '0;
      hold_cnt_q      <= '0;
      press_count_q   <= '0;
      btn_level_q     <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      long_pulse_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      stable_cnt_q    <= stable_cnt_d;
      hold_cnt_q      <= hold_cnt_d;
      press_count_q   <= press_count_d;
      btn_level_q     <= btn_level_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      long_pulse_q    <= long_pulse_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    stable_cnt_d    = stable_cnt_q;
    hold_cnt_d      = hold_cnt_q;
    press_count_d   = press_count_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    long_pulse_d    = 1'b0;

    unique case (state_q)
      StReleased: begin
        if (btn_sync) begin
          state_d      = StPressPend;
          stable_cnt_d = CntW'(1);
        end
      end
      StPressPend: begin
        if (!btn_sync) begin
          state_d      = StReleased;
          stable_cnt_d = '0;
        end else if (stable_cnt_q == DebLast) begin
          state_d       = StPressed;
          stable_cnt_d  = '0;
          hold_cnt_d    = '0;
          press_pulse_d = 1'b1;
          press_count_d = press_count_q + COUNT_WIDTH'(1);
        end else begin
          stable_cnt_d = stable_cnt_q + CntW'(1);
        end
      end
      StPressed: begin
        if (!btn_sync) begin
          state_d      = StReleasePend;
          stable_cnt_d = CntW'(1);
        end
      end
      StReleasePend: begin
        if (btn_sync) begin
          state_d      = StPressed;
          stable_cnt_d = '0;
        end else if (stable_cnt_q == DebLast) begin
          state_d         = StReleased;
          stable_cnt_d    = '0;
          hold_cnt_d      = '0;
          release_pulse_d = 1'b1;
        end else begin
          stable_cnt_d = stable_cnt_q + CntW'(1);
        end
      end
      default: state_d = StReleased;
    endcase

    // Hold time runs through release bounces; saturation makes long_pulse one-shot.
    if ((state_q == StPressed || state_q == StReleasePend) && state_d != StReleased &&
        hold_cnt_q != LongMax) begin
      hold_cnt_d = hold_cnt_q + CntW'(1);
      if (hold_cnt_q == LongPre) begin
        long_pulse_d = 1'b1;
      end
    end

    btn_level_d = (state_d == StPressed) || (state_d == StReleasePend);
  end

  assign btn_level     = btn_level_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign long_pulse    = long_pulse_q;
  assign press_count   = press_count_q;

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench: segment table, hand-written corner cases and randomised bounce stimulus.
module tb_button_debounce;

  localparam int unsigned D  = 4;
  localparam int unsigned L  = 20;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          btn_raw = 1'b0;
  logic          btn_level, press_pulse, release_pulse, long_pulse;
  logic [CW-1:0] press_count;

  always #5 clk = ~clk;

  button_debounce #(
    .DEBOUNCE_CYCLES  (D),
    .LONG_PRESS_CYCLES(L),
    .COUNT_WIDTH      (CW),
    .ACTIVE_LOW       (1'b0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .press_count  (press_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the pin is seen two edges late; a level flips after D consecutive
  // samples disagreeing with it; long press fires L-1 cycles after the press commits.
  bit          m1, m2;
  bit          lvl;
  int          run, held;
  bit          fired;
  logic [CW-1:0] mcount;
  bit          e_press, e_rel, e_long;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m1 = 1'b0; m2 = 1'b0; lvl = 1'b0; run = 0; held = 0; fired = 1'b0;
    mcount = '0; e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
  endtask

  task automatic model_edge(input bit raw);
    bit s;
    s = m2;
    e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
    if (s != lvl) run++;
    else run = 0;
    if (run == int'(D)) begin
      lvl = s;
      run = 0;
      if (s) begin
        e_press = 1'b1;
        mcount  = mcount + CW'(1);
        held    = 0;
        fired   = 1'b0;
      end else begin
        e_rel = 1'b1;
      end
    end else if (lvl) begin
      if (held < int'(L)) held++;
      if (held == int'(L) - 1 && !fired) begin
        e_long = 1'b1;
        fired  = 1'b1;
      end
    end
    m2 = m1;
    m1 = raw;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_level"},   32'(btn_level),     32'(lvl));
    chk({tag, "_press"},   32'(press_pulse),   32'(e_press));
    chk({tag, "_release"}, 32'(release_pulse), 32'(e_rel));
    chk({tag, "_long"},    32'(long_pulse),    32'(e_long));
    chk({tag, "_count"},   32'(press_count),   32'(mcount));
  endtask

  task automatic step(input bit r);
    btn_raw = r;
    @(posedge clk);
    if (rst_n) model_edge(r);
    #1;
    check_outputs("cyc");
  endtask

  task automatic do_reset(input bit r);
    btn_raw = r;
    rst_n   = 1'b0;
    model_reset();
    #1;
    check_outputs("rst");
    repeat (3) step(r);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit raw;
    int n;
    int presses;
    int releases;
    int longs;
    bit level;
    int count;
    int press_at;
    int rel_at;
  } seg_t;

  task automatic run_seg(input seg_t s, input int idx);
    int np = 0, nr = 0, nl = 0, pat = 0, rat = 0;
    for (int i = 1; i <= s.n; i++) begin
      step(s.raw);
      if (press_pulse) begin np++; if (pat == 0) pat = i; end
      if (release_pulse) begin nr++; if (rat == 0) rat = i; end
      if (long_pulse) nl++;
    end
    chk($sformatf("seg%0d_presses", idx), 32'(np), 32'(s.presses));
    chk($sformatf("seg%0d_releases", idx), 32'(nr), 32'(s.releases));
    chk($sformatf("seg%0d_longs", idx), 32'(nl), 32'(s.longs));
    chk($sformatf("seg%0d_level", idx), 32'(btn_level), 32'(s.level));
    chk($sformatf("seg%0d_count", idx), 32'(press_count), 32'(s.count));
    if (s.presses > 0) chk($sformatf("seg%0d_press_at", idx), 32'(pat), 32'(s.press_at));
    if (s.releases > 0) chk($sformatf("seg%0d_rel_at", idx), 32'(rat), 32'(s.rel_at));
  endtask

  seg_t tbl[15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog at %0t: got timeout expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int np, nr, pat;
    bit r;
    int len;

    tbl = '{
      // clean press held past long-press, then clean release
      '{1'b1, 30, 1, 0, 1, 1'b1, 1, 6, 0},
      '{1'b0, 10, 0, 1, 0, 1'b0, 1, 0, 6},
      // bounce then settle
      '{1'b1,  2, 0, 0, 0, 1'b0, 1, 0, 0},
      '{1'b0,  2, 0, 0, 0, 1'b0, 1, 0, 0},
      '{1'b1,  2, 0, 0, 0, 1'b0, 1, 0, 0},
      '{1'b0,  2, 0, 0, 0, 1'b0, 1, 0, 0},
      '{1'b1, 10, 1, 0, 0, 1'b1, 2, 6, 0},
      // release glitch while pressed: hold time keeps running
      '{1'b1,  6, 0, 0, 0, 1'b1, 2, 0, 0},
      '{1'b0,  2, 0, 0, 0, 1'b1, 2, 0, 0},
      '{1'b1, 20, 0, 0, 1, 1'b1, 2, 0, 0},
      '{1'b0, 10, 0, 1, 0, 1'b0, 2, 0, 6},
      // short press: no long pulse
      '{1'b1, 10, 1, 0, 0, 1'b1, 3, 6, 0},
      '{1'b0, 10, 0, 1, 0, 1'b0, 3, 0, 6},
      // very long hold: long pulse only once
      '{1'b1, 60, 1, 0, 1, 1'b1, 4, 6, 0},
      '{1'b0, 10, 0, 1, 0, 1'b0, 4, 0, 6}
    };

    do_reset(1'b0);
    chk("reset_level", 32'(btn_level), 32'd0);
    chk("reset_count", 32'(press_count), 32'd0);
    for (int i = 0; i < 15; i++) run_seg(tbl[i], i);

    // 17 press/release cycles from reset: count wraps 15 -> 0 -> 1
    do_reset(1'b0);
    np = 0; nr = 0;
    for (int k = 1; k <= 17; k++) begin
      repeat (8) begin step(1'b1); if (press_pulse) np++; end
      repeat (8) begin step(1'b0); if (release_pulse) nr++; end
      chk($sformatf("wrap_count_%0d", k), 32'(press_count), 32'(k % 16));
    end
    chk("wrap_presses", 32'(np), 32'd17);
    chk("wrap_releases", 32'(nr), 32'd17);

    // reset while pressed, button still held afterwards
    do_reset(1'b0);
    repeat (10) step(1'b1);
    chk("pre_rst_level", 32'(btn_level), 32'd1);
    btn_raw = 1'b1;
    rst_n   = 1'b0;
    #1;
    chk("rst_mid_level", 32'(btn_level), 32'd0);
    chk("rst_mid_count", 32'(press_count), 32'd0);
    chk("rst_mid_release", 32'(release_pulse), 32'd0);
    do_reset(1'b1);
    pat = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1'b1);
      if (press_pulse && pat == 0) pat = i;
    end
    chk("post_rst_press_at", 32'(pat), 32'd6);
    chk("post_rst_count", 32'(press_count), 32'd1);

    // randomised bouncing with occasional resets against the model
    for (int k = 0; k < 200; k++) begin
      r = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 30)) : int'($urandom_range(1, 5));
      for (int i = 0; i < len; i++) step(r);
      if ($urandom_range(0, 39) == 0) do_reset(r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
